read_responder: RTL and testbench

READ_RESPONDER -- requirements
Module: read_responder

---
 rtl/read_responder_if.sv | 28 ++
 rtl/read_responder.sv | 117 +++++++++++
 tb/tb_read_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/read_responder_if.sv
// Bundle of read request/response and loader-write signals for read_responder.
// master: the requester/loader side; slave: the responder itself.
interface read_responder_if;
    logic        read_enable_i;
    logic [15:0] read_address_i;
    logic [3:0]  read_index_i;
    logic        flush_i;
    logic        read_response_o;
    logic [31:0] read_data_o;
    logic [3:0]  read_index_o;
    logic        read_error_o;
    logic        write_enable_i;
    logic [15:0] write_address_i;
    logic [31:0] write_data_i;
    logic [3:0]  write_byte_enable_i;

    modport master (
        output read_enable_i, read_address_i, read_index_i, flush_i,
        output write_enable_i, write_address_i, write_data_i, write_byte_enable_i,
        input  read_response_o, read_data_o, read_index_o, read_error_o
    );

    modport slave (
        input  read_enable_i, read_address_i, read_index_i, flush_i,
        input  write_enable_i, write_address_i, write_data_i, write_byte_enable_i,
        output read_response_o, read_data_o, read_index_o, read_error_o
    );
endinterface

// File: rtl/read_responder.sv
// Fixed-latency word memory read responder with a byte-masked loader write port.
// Every accepted read returns exactly LATENCY (1..4) cycles later with its tag;
// misaligned or out-of-range reads still respond, with error=1 and data=0.
// Optional feature macro READ_RESPONDER_BYPASS_EN: same-cycle same-word write is
// forwarded to the read (write-first); when undefined the read sees the old word.
module read_responder #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [15:0] BASE_ADDRESS = 16'h0100,
    parameter int unsigned LATENCY      = 2
) (
    input logic               clock_i,
    input logic               reset_i,
    read_responder_if.slave   bus
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Memory is deliberately not reset so contents survive reset.
    logic [31:0] mem [DEPTH_WORDS];

    logic [15:0]   rd_offset, rd_word, wr_offset, wr_word;
    logic          rd_err, wr_err, wr_ok;
    logic [AW-1:0] rd_idx, wr_idx;
    logic [31:0]   rd_mem, rd_data;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [31:0]        data_q [LATENCY];
    logic [31:0]        data_d [LATENCY];
    logic [3:0]         idx_q  [LATENCY];
    logic [3:0]         idx_d  [LATENCY];
    logic [LATENCY-1:0] err_q, err_d;

    // Address decode for both ports: word offset with 16-bit wrap, range and alignment.
    always_comb begin
        rd_offset = bus.read_address_i - BASE_ADDRESS;
        rd_word   = {2'b00, rd_offset[15:2]};
        rd_err    = (bus.read_address_i < BASE_ADDRESS) || (32'(rd_word) >= DEPTH_WORDS) ||
                    (bus.read_address_i[1:0] != 2'b00);
        rd_idx    = rd_word[AW-1:0];
        wr_offset = bus.write_address_i - BASE_ADDRESS;
        wr_word   = {2'b00, wr_offset[15:2]};
        wr_err    = (bus.write_address_i < BASE_ADDRESS) || (32'(wr_word) >= DEPTH_WORDS) ||
                    (bus.write_address_i[1:0] != 2'b00);
        wr_idx    = wr_word[AW-1:0];
        wr_ok     = bus.write_enable_i && !wr_err;
    end

    // Read word selection, optionally merging same-cycle written bytes.
    always_comb begin
        rd_mem = mem[rd_idx];
`ifdef READ_RESPONDER_BYPASS_EN
        if (wr_ok && (wr_idx == rd_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.write_byte_enable_i[b]) begin
                    rd_mem[8*b +: 8] = bus.write_data_i[8*b +: 8];
                end
            end
        end
`endif
        rd_data = rd_err ? 32'h0 : rd_mem;
    end

    // Loader write: only enabled bytes of aligned, in-range writes land.
    always_ff @(posedge clock_i) begin
        if (wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.write_byte_enable_i[b]) begin
                    mem[wr_idx][8*b +: 8] <= bus.write_data_i[8*b +: 8];
                end
            end
        end
    end

    // Pipeline next state: stage 0 always takes the new request (even on flush),
    // later stages are squashed by flush.
    always_comb begin
        vld_d     = '0;
        err_d     = '0;
        vld_d[0]  = bus.read_enable_i;
        data_d[0] = rd_data;
        idx_d[0]  = bus.read_index_i;
        err_d[0]  = rd_err;
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k]  = vld_q[k-1] && !bus.flush_i;
            data_d[k] = data_q[k-1];
            idx_d[k]  = idx_q[k-1];
            err_d[k]  = err_q[k-1];
        end
    end

    // Pipeline registers with asynchronous clear.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
                idx_q[k]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= data_d[k];
                idx_q[k]  <= idx_d[k];
            end
        end
    end

    // Outputs: a flush also squashes the response presented in the flush cycle,
    // so every request already in the pipe loses its response.
    always_comb begin
        bus.read_response_o = vld_q[LATENCY-1] && !bus.flush_i;
        bus.read_data_o     = bus.read_response_o ? data_q[LATENCY-1] : 32'h0;
        bus.read_index_o    = bus.read_response_o ? idx_q[LATENCY-1] : 4'h0;
        bus.read_error_o    = bus.read_response_o && err_q[LATENCY-1];
    end
endmodule

// File: tb/tb_read_responder.sv
module tb_read_responder;
    localparam int unsigned LAT = 2;

    logic clock;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [3:0]  idx;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    read_responder_if bus ();

    read_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDRESS(16'h0100),
        .LATENCY     (LAT)
    ) dut (
        .clock_i(clock),
        .reset_i(reset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

`ifdef READ_RESPONDER_BYPASS_EN
    localparam logic [31:0] SAME_CYCLE_EXP = 32'h1122CCDD;
`else
    localparam logic [31:0] SAME_CYCLE_EXP = 32'h11223344;
`endif

    // Monitor: pops and compares on every response, checks idle outputs otherwise.
    always @(negedge clock) begin
        exp_t e;
        if (bus.read_response_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response cyc=%0d idx=%0d data=%h", cyc,
                         bus.read_index_o, bus.read_data_o);
            end else begin
                e = exp_q.pop_front();
                checks += 4;
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL latency idx=%0d got cyc %0d want %0d", e.idx, cyc, e.due);
                end
                if (bus.read_data_o !== e.data) begin
                    errors++;
                    $display("FAIL data idx=%0d got %h want %h", e.idx, bus.read_data_o, e.data);
                end
                if (bus.read_index_o !== e.idx) begin
                    errors++;
                    $display("FAIL index got %0d want %0d", bus.read_index_o, e.idx);
                end
                if (bus.read_error_o !== e.err) begin
                    errors++;
                    $display("FAIL error_flag idx=%0d got %b want %b", e.idx, bus.read_error_o,
                             e.err);
                end
            end
        end else begin
            checks++;
            if (bus.read_response_o !== 1'b0 || bus.read_data_o !== 32'h0 ||
                bus.read_index_o !== 4'h0 || bus.read_error_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_zero cyc=%0d got resp=%b data=%h idx=%h err=%b want all 0",
                         cyc, bus.read_response_o, bus.read_data_o, bus.read_index_o,
                         bus.read_error_o);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.read_enable_i       = 1'b0;
        bus.read_address_i      = 16'h0;
        bus.read_index_i        = 4'h0;
        bus.flush_i             = 1'b0;
        bus.write_enable_i      = 1'b0;
        bus.write_address_i     = 16'h0;
        bus.write_data_i        = 32'h0;
        bus.write_byte_enable_i = 4'h0;
    endtask

    task automatic rd(input logic [15:0] addr, input logic [3:0] idx,
                      input logic [31:0] data, input logic err);
        exp_t e;
        bus.read_enable_i  = 1'b1;
        bus.read_address_i = addr;
        bus.read_index_i   = idx;
        e.due  = cyc + LAT;
        e.data = data;
        e.idx  = idx;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.write_enable_i      = 1'b1;
        bus.write_address_i     = addr;
        bus.write_data_i        = data;
        bus.write_byte_enable_i = be;
    endtask

    task automatic check_zero_now(input string name);
        checks++;
        if (bus.read_response_o !== 1'b0 || bus.read_data_o !== 32'h0 ||
            bus.read_index_o !== 4'h0 || bus.read_error_o !== 1'b0) begin
            errors++;
            $display("FAIL %s got resp=%b data=%h idx=%h err=%b want all 0", name,
                     bus.read_response_o, bus.read_data_o, bus.read_index_o, bus.read_error_o);
        end
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle();
        repeat (3) step();
        check_zero_now("reset_outputs");

        // First edge after release: misaligned read plus a load of word 0.
        reset = 1'b0;
        rd(16'h0102, 4'd7, 32'h0, 1'b1);
        wr(16'h0100, 32'hDEADBEEF, 4'hF);
        step(); idle();
        wr(16'h0104, 32'h11223344, 4'hF); step(); idle();
        wr(16'h0108, 32'hCAFEF00D, 4'hF); step(); idle();
        wr(16'h10FC, 32'h0BADC0DE, 4'hF); step(); idle();

        rd(16'h0100, 4'd5, 32'hDEADBEEF, 1'b0); step(); idle();
        repeat (3) step();

        // Back-to-back reads in order.
        rd(16'h0100, 4'd1, 32'hDEADBEEF, 1'b0); step(); idle();
        rd(16'h0104, 4'd2, 32'h11223344, 1'b0); step(); idle();
        rd(16'h0108, 4'd3, 32'hCAFEF00D, 1'b0); step(); idle();

        // Range boundaries.
        rd(16'h00FC, 4'd4, 32'h0, 1'b1);        step(); idle();
        rd(16'h1100, 4'd6, 32'h0, 1'b1);        step(); idle();
        rd(16'h10FC, 4'd8, 32'h0BADC0DE, 1'b0); step(); idle();
        rd(16'hFFFC, 4'd9, 32'h0, 1'b1);        step(); idle();
        repeat (3) step();

        // Flush with two reads in flight; the read on the flush cycle survives.
        rd(16'h0100, 4'd10, 32'hDEADBEEF, 1'b0); step(); idle();
        rd(16'h0104, 4'd11, 32'h11223344, 1'b0); step(); idle();
        exp_q.delete();
        bus.flush_i = 1'b1;
        rd(16'h0108, 4'd12, 32'hCAFEF00D, 1'b0); step(); idle();
        repeat (3) step();

        // Same-cycle write and read of one word.
        wr(16'h0104, 32'hAABBCCDD, 4'b0011);
        rd(16'h0104, 4'd13, SAME_CYCLE_EXP, 1'b0); step(); idle();
        rd(16'h0104, 4'd14, 32'h1122CCDD, 1'b0);   step(); idle();

        // Misaligned and out-of-range writes must be dropped.
        wr(16'h0101, 32'hFFFFFFFF, 4'hF); step(); idle();
        wr(16'h1100, 32'hFFFFFFFF, 4'hF); step(); idle();
        rd(16'h0100, 4'd15, 32'hDEADBEEF, 1'b0); step(); idle();
        rd(16'h10FC, 4'd0, 32'h0BADC0DE, 1'b0);  step(); idle();
        repeat (3) step();

        // Asynchronous reset while one response is showing and another is in flight.
        rd(16'h0108, 4'd1, 32'hCAFEF00D, 1'b0); step(); idle();
        rd(16'h0100, 4'd2, 32'hDEADBEEF, 1'b0); step(); idle();
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_zero_now("async_reset_outputs");
        step(); step();
        reset = 1'b0;
        repeat (4) step();
        rd(16'h0100, 4'd3, 32'hDEADBEEF, 1'b0); step(); idle();
        rd(16'h0104, 4'd4, 32'h1122CCDD, 1'b0); step(); idle();
        repeat (4) step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_responses got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
